// File: rtl/array_sequencer.sv
// Control sequencer for the 25x25 SIMD array: fetches, decodes and broadcasts kernel instructions.
// Define SEQ_SINGLE_STEP_EN to add step_req/step_wait single-stepping of array ops.
module array_sequencer #(
  parameter int PC_W    = 10,
  parameter int SP_W    = 4,
  parameter int INSTR_W = 32,
  parameter int ENTRY   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    next_program_counter,
  output logic [SP_W-1:0]    next_stack_pointer,
  output logic               global_enable,
  input  logic               diverge_consensus,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [15:0]        gen_count
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic               step_req,
  output logic               step_wait
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_t;

  localparam logic [PC_W-1:0] ENTRY_PC = PC_W'(ENTRY);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] sp;
  logic [PC_W-1:0] stack [2**SP_W];

  logic [3:0]      op;
  logic [PC_W-1:0] tgt;
  logic            in_exec;
  logic            is_array, is_jmp, is_brc, is_call, is_ret, is_halt;
  logic            stack_err;
  logic            stall;
  logic [PC_W-1:0] npc;
  logic [SP_W-1:0] nsp;

  assign op      = instruction[INSTR_W-1 -: 4];
  assign tgt     = instruction[PC_W-1:0];
  assign in_exec = (state == EXEC);

  assign is_array = (op < 4'hC);
  assign is_jmp   = (op == 4'hC);
  assign is_brc   = (op == 4'hD);
  assign is_call  = (op == 4'hE);
  assign is_ret   = (op == 4'hF) && !instruction[INSTR_W-5];
  assign is_halt  = (op == 4'hF) &&  instruction[INSTR_W-5];

  // The top stack entry is reserved, so a CALL at sp == all-ones overflows.
  assign stack_err = in_exec && ((is_call && (sp == '1)) || (is_ret && (sp == '0)));

`ifdef SEQ_SINGLE_STEP_EN
  assign stall     = is_array && !step_req;
  assign step_wait = in_exec && is_array && !step_req;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    npc = pc;
    nsp = sp;
    if (in_exec && !stack_err) begin
      if (is_array) begin
        npc = pc + 1'b1;
      end else if (is_jmp) begin
        npc = tgt;
      end else if (is_brc) begin
        npc = diverge_consensus ? tgt : pc + 1'b1;
      end else if (is_call) begin
        npc = tgt;
        nsp = sp + 1'b1;
      end else if (is_ret) begin
        npc = stack[sp - 1'b1];
        nsp = sp - 1'b1;
      end
    end
  end

  assign next_program_counter = npc;
  assign next_stack_pointer   = nsp;
  assign global_enable        = in_exec && is_array && !stall && !abort;
  assign done                 = in_exec && is_halt && !abort;
  assign busy                 = (state == FETCH) || (state == EXEC);

  always_ff @(posedge clk) begin
    if (!rst && !abort && in_exec && is_call && !stack_err) begin
      stack[sp] <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      sp          <= '0;
      imem_addr   <= '0;
      instruction <= '0;
      fault       <= 1'b0;
      gen_count   <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, FAULT: begin
          if (start) begin
            pc        <= ENTRY_PC;
            sp        <= '0;
            imem_addr <= ENTRY_PC;
            fault     <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          instruction <= imem_rdata;
          state       <= EXEC;
        end
        EXEC: begin
          if (stack_err) begin
            fault <= 1'b1;
            state <= FAULT;
          end else if (is_halt) begin
            gen_count <= gen_count + 16'd1;
            state     <= IDLE;
          end else if (!stall) begin
            pc        <= npc;
            sp        <= nsp;
            imem_addr <= npc;
            state     <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/array_sequencer.md
Name: array_sequencer

Overview:
- Central control unit for the 25x25 SIMD cell array.
- Fetches kernel instructions from a synchronous instruction ROM and broadcasts them to all cells with a one-cycle global_enable strobe.
- Owns the program counter and a hardware call stack, and resolves control flow: jump, call, return, halt, and branch-on-diverge_consensus.
- Drives next_program_counter and next_stack_pointer so per-cell divergence logic tracks the same control flow.

Parameters:
- PC_W, 10, program counter / ROM address width
- SP_W, 4, stack pointer width; stack depth = 2**SP_W entries
- INSTR_W, 32, instruction width
- ENTRY, 0, PC loaded on start

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run at ENTRY (ignored unless IDLE)
- abort  in  1  stops the run and returns to IDLE
- imem_addr  out  PC_W  ROM address; data returns next cycle
- imem_rdata  in  INSTR_W  ROM data
- instruction  out  INSTR_W  broadcast instruction to the array
- next_program_counter  out  PC_W  PC after the current instruction
- next_stack_pointer  out  SP_W  SP after the current instruction
- global_enable  out  1  array commit strobe
- diverge_consensus  in  1  AND of all cell diverge flags
- busy  out  1  high in FETCH/EXEC
- done  out  1  one-cycle pulse on HALT
- fault  out  1  sticky stack error, cleared by start or rst
- gen_count  out  16  completed runs, wraps at 0xFFFF

Behaviour:
- Reset values:
  - FSM in IDLE.
  - pc, sp, imem_addr, instruction, next_program_counter, next_stack_pointer, gen_count: 0.
  - global_enable, busy, done, fault: 0.
  - Stack contents are don't-care.
- FSM states: IDLE, FETCH, EXEC, FAULT.
- IDLE:
  - On start: pc <= ENTRY, imem_addr <= ENTRY, fault <= 0, go to FETCH.
- FETCH:
  - Waits one cycle for ROM latency.
  - Then instruction <= imem_rdata, go to EXEC.
- Decode in EXEC, by op = instruction[INSTR_W-1:INSTR_W-4] and tgt = instruction[PC_W-1:0]:
  - 0x0-0xB, array op: global_enable=1 for exactly this cycle; npc = pc+1.
  - 0xC, JMP: npc = tgt.
  - 0xD, BRC: npc = diverge_consensus ? tgt : pc+1. diverge_consensus is sampled in the EXEC cycle.
  - 0xE, CALL: stack[sp] <= pc+1; sp+1; npc = tgt.
  - 0xF with bit INSTR_W-5 = 0, RET: sp-1; npc = stack[sp-1].
  - 0xF with bit INSTR_W-5 = 1, HALT: done=1, gen_count+1, go to IDLE.
- EXEC timing:
  - global_enable is 0 for all control ops.
  - next_program_counter and next_stack_pointer are valid combinationally during EXEC.
  - They are registered into pc/sp at the end of EXEC; imem_addr <= npc, then FETCH.
  - Every non-halting instruction therefore takes exactly 2 cycles.
- PC arithmetic: modulo 2**PC_W; pc+1 from all-ones wraps to 0 with no fault.
- Stack error:
  - Triggers: CALL with sp == 2**SP_W-1, or RET with sp == 0.
  - Response: no push/pop, global_enable=0, fault <= 1, go to FAULT.
  - FAULT holds until start, which behaves as start from IDLE.
  - One entry is reserved, so usable depth is 2**SP_W-1.
- abort:
  - Takes effect the next cycle from any state; FSM goes to IDLE.
  - If asserted during EXEC of an array op, global_enable is forced to 0 that cycle (no commit).
  - done is not pulsed; gen_count is unchanged.
- Simultaneous events:
  - abort and start in the same cycle: abort wins.
  - start while busy is ignored.
  - rst overrides everything.
- busy = (state == FETCH || state == EXEC).

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step_req (1 bit) and output step_wait (1 bit).
  - EXEC of an array op stalls with global_enable=0 and step_wait=1 until step_req=1.
  - global_enable fires in the same cycle step_req is seen.
  - Control ops never stall.
  - abort still works during a stall.
- Undefined: the ports do not exist and the block runs free as described above.

Test Plan:
- ROM {0:0x10000000, 1:0x10000000, 2:HALT}, pulse start -> global_enable high on cycles 2 and 4 after start, done on cycle 6, gen_count=1, next_program_counter 1, 2 during those EXECs.
- BRC to 0x005 at addr 0, diverge_consensus=1 -> next_program_counter=5, imem_addr=5 in the following FETCH; with diverge_consensus=0 -> 1.
- CALL 0x020 at 3, RET at 0x020 -> sp 0→1→0, next_program_counter 0x020 then 4, global_enable never asserted for either.
- Recursive CALL to self with SP_W=2 -> fault after third CALL (sp=3), FSM in FAULT, busy=0; start clears fault and reruns from ENTRY.
- abort during EXEC of an array op -> global_enable=0 that cycle, IDLE next cycle, no done, gen_count unchanged; rst mid-run -> all outputs 0.
- With SEQ_SINGLE_STEP_EN: step_req held low 10 cycles -> step_wait=1, global_enable=0 throughout; a step_req pulse -> one global_enable in the same cycle.
